// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_e   : frame-sequencing state encoding
//   calc_bitlim()  : clocks per bit for a given clock/baud pair
//   calc_halflim() : clocks to the middle of a bit (integer half of bitlim)
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_bitlim(input int clkfreq, input int baudrate);
    return clkfreq / baudrate;
  endfunction

  function automatic int calc_halflim(input int clkfreq, input int baudrate);
    return calc_bitlim(clkfreq, baudrate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input.
// Both flops reset to 1 so that an idle-high serial line does not produce a
// false start edge when reset is released.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: 1 start bit, p_databits data bits (LSB first),
// stop bit sampled at mid-bit. Only the first stop bit is looked at; any
// further stop bits simply read as idle line.
//   clk            : system clock (p_clkfreq Hz), rising edge
//   rst_n          : asynchronous active-low reset
//   rx_i           : asynchronous serial input, idle high
//   dout_o         : last correctly received word, held between frames
//   rx_done_tick_o : one-clk pulse when dout_o has just been updated
//   frame_err_o    : one-clk pulse when the stop bit is sampled low
// Build option: define UART_RX_FRAME_ERR_EN to enable stop-bit checking.
// Without it the stop sample is ignored and frame_err_o is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for a low level on the synchronized rx
// START   | timing to mid start bit; high there means it was a glitch
// DATA    | sampling p_databits data bits, one every bit time
// STOP    | sampling the stop bit, then publishing the word (or error)
module uart_rx
  import uart_pkg::*;
#(
  parameter int p_clkfreq  = 100_000_000,
  parameter int p_baudrate = 10_000_000,
  parameter int p_databits = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  output logic [p_databits-1:0] dout_o,
  output logic                  rx_done_tick_o,
  output logic                  frame_err_o
);

  localparam int BITLIM  = calc_bitlim(p_clkfreq, p_baudrate);
  localparam int HALFLIM = calc_halflim(p_clkfreq, p_baudrate);
  localparam int TW      = (BITLIM > 1) ? $clog2(BITLIM) : 1;
  localparam int CW      = $clog2(p_databits + 1);

  localparam logic [TW-1:0] BIT_TC   = TW'(BITLIM - 1);
  localparam logic [TW-1:0] HALF_TC  = TW'(HALFLIM - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(p_databits - 1);

  logic                  rx_sync;
  uart_state_e           state;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         bitcnt;
  logic [p_databits-1:0] shreg;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      bitcnt         <= '0;
      shreg          <= '0;
      dout_o         <= '0;
      rx_done_tick_o <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_o    <= 1'b0;
`endif
    end else begin
      rx_done_tick_o <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_o    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state  <= ST_START;
            timer  <= '0;
            bitcnt <= '0;
          end
        end

        ST_START: begin
          if (timer == HALF_TC) begin
            timer <= '0;
            state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer == BIT_TC) begin
            timer  <= '0;
            // LSB arrives first, so shifting right from the MSB end leaves
            // bit 0 in place after the last sample.
            shreg  <= {rx_sync, shreg[p_databits-1:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) begin
              state <= ST_STOP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer == BIT_TC) begin
            timer <= '0;
            state <= ST_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_sync) begin
              dout_o         <= shreg;
              rx_done_tick_o <= 1'b1;
            end else begin
              frame_err_o    <= 1'b1;
            end
`else
            dout_o         <= shreg;
            rx_done_tick_o <= 1'b1;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          timer  <= '0;
          bitcnt <= '0;
        end
      endcase
    end
  end

`ifndef UART_RX_FRAME_ERR_EN
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  // Bit times in clocks: 100 MHz / 10 Mbaud and 100 MHz / 5 Mbaud.
  localparam int BT_A = 10;
  localparam int BT_B = 20;
  localparam int N_LOOP = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [9:0] dout_a, dout_b;
  logic       tick_a, tick_b, err_a, err_b;

  always #5 clk = ~clk;

  uart_rx dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_i           (rx_a),
    .dout_o         (dout_a),
    .rx_done_tick_o (tick_a),
    .frame_err_o    (err_a)
  );

  uart_rx #(.p_clkfreq(100_000_000), .p_baudrate(5_000_000), .p_databits(10)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_i           (rx_b),
    .dout_o         (dout_b),
    .rx_done_tick_o (tick_b),
    .frame_err_o    (err_b)
  );

  int checks = 0;
  int failures = 0;

  // Output monitor: collects published words, error pulses and pulse-rule
  // violations (tick and error together, or any pulse wider than one clk).
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int     err_cnt_a = 0, err_cnt_b = 0, proto_viol = 0;
  longint last_tick_a = 0;
  logic   p_tick_a = 0, p_err_a = 0, p_tick_b = 0, p_err_b = 0;

  always @(negedge clk) begin
    if (tick_a) begin
      q_a.push_back(dout_a);
      last_tick_a = $time;
    end
    if (tick_b) q_b.push_back(dout_b);
    if (err_a) err_cnt_a++;
    if (err_b) err_cnt_b++;
    if ((tick_a && err_a) || (tick_b && err_b)) proto_viol++;
    if ((tick_a && p_tick_a) || (err_a && p_err_a) ||
        (tick_b && p_tick_b) || (err_b && p_err_b)) proto_viol++;
    p_tick_a = tick_a; p_err_a = err_a;
    p_tick_b = tick_b; p_err_b = err_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int sel, input logic v, input int nclk);
    if (sel == 0) rx_a = v; else rx_b = v;
    repeat (nclk) @(negedge clk);
  endtask

  // Serial frame: start, 10 data bits LSB first, first stop bit as given,
  // then (nstop-1) further high stop bits.
  task automatic send_frame(input int sel, input logic [9:0] w, input int bt,
                            input logic stop_v, input int nstop);
    drive_line(sel, 1'b0, bt);
    for (int i = 0; i < 10; i++) drive_line(sel, w[i], bt);
    drive_line(sel, stop_v, bt);
    for (int i = 1; i < nstop; i++) drive_line(sel, 1'b1, bt);
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
  endtask

  logic [9:0] exp_q[$];
  logic [9:0] word;
  logic [9:0] prior;
  longint     t_fall;
  int         lat;
  int         err_before;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_dout", dout_a, 10'h000);
    check("rst_tick", tick_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_state", dut_a.state, ST_IDLE);

    // Single frame, two stop bits, latency from start edge
    q_a.delete();
    t_fall = $time;
    send_frame(0, 10'h2A5, BT_A, 1'b1, 2);
    repeat (20) @(negedge clk);
    check("single_count", q_a.size(), 1);
    check("single_dout", (q_a.size() > 0) ? q_a[0] : 10'hxxx, 10'h2A5);
    lat = int'((last_tick_a - t_fall) / 10);
    check("latency_116_118", ((lat >= 116) && (lat <= 118)) ? lat : 0, lat);
    check("single_no_err", err_cnt_a, 0);

    // Back-to-back frames, single stop bit
    q_a.delete();
    exp_q.delete();
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h155);
    foreach (exp_q[i]) send_frame(0, exp_q[i], BT_A, 1'b1, 1);
    repeat (30) @(negedge clk);
    check("b2b_count", q_a.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_word%0d", i), (i < q_a.size()) ? q_a[i] : 10'hxxx, exp_q[i]);
    check("b2b_no_err", err_cnt_a, 0);
    check("b2b_dout_hold", dout_a, 10'h155);

    // 3-clk glitch on idle line
    q_a.delete();
    drive_line(0, 1'b0, 3);
    drive_line(0, 1'b1, 8);
    check("glitch_idle", dut_a.state, ST_IDLE);
    repeat (150) @(negedge clk);
    check("glitch_no_tick", q_a.size(), 0);
    check("glitch_no_err", err_cnt_a, 0);

    // Stop bit forced low
    prior = dout_a;
    err_before = err_cnt_a;
    send_frame(0, 10'h0F0, BT_A, 1'b0, 1);
    drive_line(0, 1'b1, 40);
    if (FE_EN) begin
      check("ferr_pulses", err_cnt_a - err_before, 1);
      check("ferr_no_tick", q_a.size(), 0);
      check("ferr_dout_kept", dout_a, prior);
    end else begin
      check("noferr_err_low", err_cnt_a - err_before, 0);
      check("noferr_tick", q_a.size(), 1);
      check("noferr_dout", dout_a, 10'h0F0);
    end

    // Reset in the middle of DATA, then a fresh frame
    word = 10'h1C3;
    drive_line(0, 1'b0, BT_A);
    for (int i = 0; i < 4; i++) drive_line(0, word[i], BT_A);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout_a, 10'h000);
    check("midrst_tick", tick_a, 1'b0);
    check("midrst_err", err_a, 1'b0);
    check("midrst_state", dut_a.state, ST_IDLE);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    q_a.delete();
    err_before = err_cnt_a;
    send_frame(0, 10'h03C, BT_A, 1'b1, 1);
    repeat (30) @(negedge clk);
    check("after_rst_count", q_a.size(), 1);
    check("after_rst_dout", (q_a.size() > 0) ? q_a[0] : 10'hxxx, 10'h03C);
    check("after_rst_no_err", err_cnt_a - err_before, 0);

    // Random loopback at 5 Mbaud, back-to-back, single stop bit
    q_b.delete();
    exp_q.delete();
    for (int n = 0; n < N_LOOP; n++) begin
      word = 10'($urandom_range(0, 1023));
      exp_q.push_back(word);
      send_frame(1, word, BT_B, 1'b1, 1);
    end
    repeat (60) @(negedge clk);
    check("loop_count", q_b.size(), N_LOOP);
    for (int n = 0; n < N_LOOP; n++)
      check($sformatf("loop_word%0d", n), (n < q_b.size()) ? q_b[n] : 10'hxxx, exp_q[n]);
    check("loop_no_err", err_cnt_b, 0);

    check("pulse_rules", proto_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter p_clkfreq, default 100_000_000, is the system clock frequency in Hz.
REQ-002 Parameter p_baudrate, default 10_000_000, is the line bit rate in baud.
REQ-003 Parameter p_databits, default 10, is the number of data bits per frame, LSB first.
REQ-004 Port clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-006 Port rx_i  input  1  is the asynchronous serial line, idle high.
REQ-007 Port dout_o  output  p_databits  is the last correctly received data word.
REQ-008 Port rx_done_tick_o  output  1  is a one-clk pulse marking dout_o as newly valid.
REQ-009 Port frame_err_o  output  1  is a one-clk pulse on a low stop-bit sample.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer before use; all timing below counts from the synchronized signal.
REQ-011 Derived constants: BITLIM = p_clkfreq/p_baudrate clks; HALFLIM = BITLIM/2 (integer); bit timer width = $clog2(BITLIM).
REQ-012 States SHALL be IDLE, START, DATA, STOP; any illegal encoding SHALL go to IDLE next clk.
REQ-013 IDLE: synchronized rx low -> START, bit timer = 0, bit counter = 0.
REQ-014 START: at timer == HALFLIM-1, rx low -> DATA with timer = 0; rx high -> IDLE as a glitch, with no output pulse.
REQ-015 DATA: at each timer == BITLIM-1, sample rx into shift-register MSB and shift right, increment bit counter, timer = 0.
REQ-016 DATA -> STOP after the p_databits-th sample.
REQ-017 STOP: at timer == BITLIM-1, sample rx; high -> load dout_o from shift register, pulse rx_done_tick_o, go to IDLE.
REQ-018 Only the first stop bit SHALL be checked; extra stop bits are treated as idle line.
REQ-019 rx_done_tick_o and frame_err_o SHALL never be high in the same clk and SHALL be high for exactly one clk per frame.
REQ-020 Latency SHALL be 2 + HALFLIM + (p_databits+1)*BITLIM clks, ±1, from the rx_i falling edge to rx_done_tick_o; default values give 117.
REQ-021 dout_o SHALL hold its value between frames.
REQ-022 Back-to-back frames with a single stop bit SHALL be received without loss.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, timers and counters = 0, dout_o = 0, rx_done_tick_o = 0, frame_err_o = 0, and both synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, the next falling edge on rx starts a new frame.

Configuration
REQ-025 Macro UART_RX_FRAME_ERR_EN SHALL select stop-bit checking.
REQ-026 With UART_RX_FRAME_ERR_EN defined, a low stop sample SHALL pulse frame_err_o, leave dout_o unchanged, suppress rx_done_tick_o, and go to IDLE.
REQ-027 Without the macro, the stop sample is ignored: dout_o loads and rx_done_tick_o pulses always; frame_err_o is tied 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding typedef and the BITLIM/HALFLIM computation functions, shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff, reset to 1.

Verification
REQ-030 Drive frame 10'h2A5 at 10 Mbaud, 2 stop bits -> one rx_done_tick_o, dout_o = 10'h2A5, 117±1 clks after the start edge.
REQ-031 Drive 3 back-to-back frames 10'h000, 10'h3FF, 10'h155, 1 stop bit -> three ticks, values in order, no frame_err_o.
REQ-032 Drive a 3-clk low glitch on idle rx -> no tick, no error, state back to IDLE within 8 clks.
REQ-033 With UART_RX_FRAME_ERR_EN, send 10'h0F0 with stop bit forced low -> frame_err_o pulses once, no tick, dout_o keeps its prior value; without the macro -> tick with dout_o = 10'h0F0.
REQ-034 Assert rst_n low mid-DATA of frame 10'h1C3, release, send 10'h03C -> all outputs 0 during reset, then exactly one tick with dout_o = 10'h03C.
REQ-035 Loop the transmitter to the receiver at p_baudrate = 5_000_000 with 256 random words -> every word matches and no errors occur.
